// File: rtl/proc_subsystem_reset_seq_if.sv
// Reset-sequencer signal bundle: asynchronous request inputs, debug/clear
// pulses, the two ordered reset outputs and the cause/lock-loss status.
interface proc_subsystem_reset_seq_if;
    logic       pll_lock;
    logic       ext_rst_n;
    logic       debug_rst_req;
    logic       cause_clr;
    logic       fabric_reset_n;
    logic       cpu_reset_n;
    logic [3:0] reset_cause;
    logic [7:0] lock_lost_cnt;

    modport master (
        output pll_lock, ext_rst_n, debug_rst_req, cause_clr,
        input  fabric_reset_n, cpu_reset_n, reset_cause, lock_lost_cnt
    );

    modport slave (
        input  pll_lock, ext_rst_n, debug_rst_req, cause_clr,
        output fabric_reset_n, cpu_reset_n, reset_cause, lock_lost_cnt
    );
endinterface

// File: rtl/proc_subsystem_reset_seq.sv
// Reset sequencer behind the processor-subsystem CCC. Qualifies PLL lock,
// releases the fabric reset first and the CPU reset a fixed hold later,
// supports a CPU-only debug reset and records why the last reset happened.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | both resets asserted, waiting for synced lock and ext high
// STABLE    | both asserted, counting LOCK_STABLE_CYCLES of good lock
// FAB_REL   | fabric released, CPU held for RESET_HOLD_CYCLES
// RUN       | both released
// CPU_HOLD  | debug CPU-only reset, CPU held for RESET_HOLD_CYCLES
module proc_subsystem_reset_seq #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int CNT_WIDTH          = 16
) (
    input logic                       clk,
    input logic                       rst_n,
    proc_subsystem_reset_seq_if.slave rs
);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        FAB_REL,
        RUN,
        CPU_HOLD
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LOCK_TC = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_TC = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 fab_q;
    logic                 cpu_q;
    logic [3:0]           cause_q;
    logic [7:0]           lost_q;
    logic                 lock_q1;
    logic                 lock_s;
    logic                 ext_q1;
    logic                 ext_s;
    logic                 lock_lost;
    logic                 ext_req;
    logic                 abort;
    logic                 dbg_hit;

    // Lock loss and external reset only count as aborts once the sequence has started;
    // the debug request is only honoured when the whole subsystem is running.
    assign lock_lost = (state_q != WAIT_LOCK) && !lock_s;
    assign ext_req   = (state_q != WAIT_LOCK) && !ext_s;
    assign abort     = lock_lost || ext_req;
    assign dbg_hit   = (state_q == RUN) && rs.debug_rst_req && !abort;

    // Two-flop synchronizers for the asynchronous lock and pushbutton inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q1 <= 1'b0;
            lock_s  <= 1'b0;
            ext_q1  <= 1'b0;
            ext_s   <= 1'b0;
        end else begin
            lock_q1 <= rs.pll_lock;
            lock_s  <= lock_q1;
            ext_q1  <= rs.ext_rst_n;
            ext_s   <= ext_q1;
        end
    end

    // Sequencing FSM; reset outputs are set on the edge that enters each state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            fab_q   <= 1'b0;
            cpu_q   <= 1'b0;
        end else if (abort) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            fab_q   <= 1'b0;
            cpu_q   <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    fab_q <= 1'b0;
                    cpu_q <= 1'b0;
                    if (lock_s && ext_s) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end
                end
                STABLE: begin
                    if (cnt_q == LOCK_TC) begin
                        state_q <= FAB_REL;
                        cnt_q   <= '0;
                        fab_q   <= 1'b1;
                        cpu_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FAB_REL: begin
                    if (cnt_q == HOLD_TC) begin
                        state_q <= RUN;
                        cpu_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (dbg_hit) begin
                        state_q <= CPU_HOLD;
                        cnt_q   <= '0;
                        cpu_q   <= 1'b0;
                    end
                end
                CPU_HOLD: begin
                    if (cnt_q == HOLD_TC) begin
                        state_q <= RUN;
                        cpu_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= WAIT_LOCK;
                    cnt_q   <= '0;
                    fab_q   <= 1'b0;
                    cpu_q   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky cause bits: a cause setting in the same cycle as a clear survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_q <= 4'b0001;
        end else begin
            cause_q <= (cause_q & ~{4{rs.cause_clr}}) | {dbg_hit, ext_req, lock_lost, 1'b0};
        end
    end

    // Saturating lock-loss event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_q <= 8'h00;
        end else if (lock_lost && (lost_q != 8'hFF)) begin
            lost_q <= lost_q + 8'h01;
        end
    end

    assign rs.fabric_reset_n = fab_q;
    assign rs.cpu_reset_n    = cpu_q;
    assign rs.reset_cause    = cause_q;
    assign rs.lock_lost_cnt  = lost_q;

endmodule

// File: tb/tb_proc_subsystem_reset_seq.sv
// Scoreboard bench for the reset sequencer: stimulus tasks push the expected
// output snapshots (with the edge number they must appear on) and a monitor
// pops one entry every time the DUT outputs change.
module tb_proc_subsystem_reset_seq;
    localparam int LSC = 8;
    localparam int HRC = 4;

    typedef struct {
        int         cyc;
        logic       fab;
        logic       cpu;
        logic [3:0] cause;
        logic [7:0] cnt;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    ev_t         sb_q[$];
    ev_t         e;
    logic [13:0] cur;
    logic [13:0] last_snap = {1'b0, 1'b0, 4'b0001, 8'h00};

    logic [3:0]  m_cause;
    logic [7:0]  m_cnt;
    logic [13:0] m_last;

    int p, q, t0, op;

    proc_subsystem_reset_seq_if rs_if ();

    proc_subsystem_reset_seq #(
        .LOCK_STABLE_CYCLES(LSC),
        .RESET_HOLD_CYCLES (HRC),
        .CNT_WIDTH         (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rs   (rs_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: keeps the externally visible outputs and pushes a new
    // snapshot only when something visible is supposed to change.
    task automatic push_snap(int c, logic f, logic u);
        logic [13:0] s;
        ev_t ev;
        s = {f, u, m_cause, m_cnt};
        if (s !== m_last) begin
            ev.cyc = c; ev.fab = f; ev.cpu = u; ev.cause = m_cause; ev.cnt = m_cnt;
            sb_q.push_back(ev);
            m_last = s;
        end
    endtask

    task automatic abort_model(int c, bit lk, bit ex, bit clr);
        m_cause = (clr ? 4'b0000 : m_cause) | {1'b0, ex, lk, 1'b0};
        if (lk && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        push_snap(c, 1'b0, 1'b0);
    endtask

    task automatic reseq(int start);
        push_snap(start + LSC, 1'b1, 1'b0);
        push_snap(start + LSC + HRC, 1'b1, 1'b1);
    endtask

    // Drop lock and/or ext for w cycles; optionally pulse cause_clr on the abort edge.
    task automatic glitch(bit lk, bit ex, int w, bit clr_at_abort);
        int pp;
        int n;
        @(negedge clk);
        pp = cyc;
        if (lk) rs_if.pll_lock = 1'b0;
        if (ex) rs_if.ext_rst_n = 1'b0;
        abort_model(pp + 3, lk, ex, clr_at_abort);
        reseq(pp + w + 3);
        n = (w > 3) ? w : 3;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            rs_if.cause_clr = clr_at_abort && (cyc == pp + 2);
            if (cyc == pp + w) begin
                rs_if.pll_lock  = 1'b1;
                rs_if.ext_rst_n = 1'b1;
            end
        end
        rs_if.cause_clr = 1'b0;
    endtask

    task automatic dbg_pulse(int second);
        int pp;
        @(negedge clk);
        pp = cyc;
        rs_if.debug_rst_req = 1'b1;
        m_cause = m_cause | 4'b1000;
        push_snap(pp + 1, 1'b1, 1'b0);
        push_snap(pp + 1 + HRC, 1'b1, 1'b1);
        @(negedge clk);
        rs_if.debug_rst_req = 1'b0;
        if (second != 0) begin
            while (cyc < pp + second) @(negedge clk);
            rs_if.debug_rst_req = 1'b1;
            @(negedge clk);
            rs_if.debug_rst_req = 1'b0;
        end
    endtask

    task automatic clr_pulse();
        int pp;
        @(negedge clk);
        pp = cyc;
        rs_if.cause_clr = 1'b1;
        m_cause = 4'b0000;
        push_snap(pp + 1, 1'b1, 1'b1);
        @(negedge clk);
        rs_if.cause_clr = 1'b0;
    endtask

    task automatic wait_drain(int budget, string name);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s_timeout: %0d events pending after %0d cycles, expected 0",
                     name, sb_q.size(), budget);
            sb_q.delete();
        end
    endtask

    // Monitor: every visible output change must match the next expected snapshot and edge.
    always begin
        @(negedge clk);
        #1;
        cur = {rs_if.fabric_reset_n, rs_if.cpu_reset_n, rs_if.reset_cause, rs_if.lock_lost_cnt};
        if (cur !== last_snap) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_change: cycle %0d fab=%b cpu=%b cause=%b cnt=%0d, expected no change",
                         cyc, cur[13], cur[12], cur[11:8], cur[7:0]);
            end else begin
                e = sb_q.pop_front();
                if (e.cyc == cyc && cur === {e.fab, e.cpu, e.cause, e.cnt}) begin
                    n_pass++;
                end else begin
                    $display("FAIL event: got cycle %0d fab=%b cpu=%b cause=%b cnt=%0d, expected cycle %0d fab=%b cpu=%b cause=%b cnt=%0d",
                             cyc, cur[13], cur[12], cur[11:8], cur[7:0],
                             e.cyc, e.fab, e.cpu, e.cause, e.cnt);
                end
            end
            last_snap = cur;
        end
    end

    initial begin
        rs_if.pll_lock      = 1'b1;
        rs_if.ext_rst_n     = 1'b1;
        rs_if.debug_rst_req = 1'b0;
        rs_if.cause_clr     = 1'b0;
        rst_n               = 1'b1;
        m_cause = 4'b0001;
        m_cnt   = 8'h00;
        m_last  = {1'b0, 1'b0, 4'b0001, 8'h00};
        #1 rst_n = 1'b0;

        // Reset state
        repeat (5) @(negedge clk);
        check("reset_fab", rs_if.fabric_reset_n, 0);
        check("reset_cpu", rs_if.cpu_reset_n, 0);
        check("reset_cause", rs_if.reset_cause, 4'b0001);
        check("reset_lostcnt", rs_if.lock_lost_cnt, 0);

        // Power-up: STABLE entered 3 edges after release
        p = cyc;
        rst_n = 1'b1;
        reseq(p + 3);
        wait_drain(40, "power_up");
        check("powerup_cause", rs_if.reset_cause, 4'b0001);

        // One-cycle lock drop in RUN
        glitch(1'b1, 1'b0, 1, 1'b0);
        wait_drain(60, "lock_drop");
        check("lockdrop_cause", rs_if.reset_cause, 4'b0011);
        check("lockdrop_cnt", rs_if.lock_lost_cnt, 1);

        // Lock glitch while STABLE at cnt=5, with an ignored debug request in STABLE
        @(negedge clk);
        p = cyc;
        rs_if.pll_lock = 1'b0;
        abort_model(p + 3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rs_if.pll_lock = 1'b1;
        t0 = p + 4;
        while (cyc < t0 + 1) @(negedge clk);
        rs_if.debug_rst_req = 1'b1;
        @(negedge clk);
        rs_if.debug_rst_req = 1'b0;
        @(negedge clk);
        rs_if.pll_lock = 1'b0;
        abort_model(t0 + 6, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rs_if.pll_lock = 1'b1;
        reseq(t0 + 7);
        while (cyc < t0 + LSC) @(negedge clk);
        #2 check("no_partial_credit", rs_if.fabric_reset_n, 0);
        wait_drain(60, "stable_glitch");
        check("stable_glitch_cause3", rs_if.reset_cause[3], 0);

        // Debug CPU-only reset with a second request during the hold
        dbg_pulse($urandom_range(2, 3));
        wait_drain(30, "debug");
        check("debug_cause3", rs_if.reset_cause[3], 1);

        clr_pulse();
        wait_drain(10, "cause_clr");

        // Lock and ext fall together, clear lands on the abort edge
        glitch(1'b1, 1'b1, $urandom_range(1, 4), 1'b1);
        wait_drain(60, "dual_abort");
        check("dual_abort_cause", rs_if.reset_cause, 4'b0110);
        check("dual_abort_cnt", rs_if.lock_lost_cnt, m_cnt);

        // Randomised mix of events from RUN
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            op = $urandom_range(0, 3);
            case (op)
                0: glitch(1'b1, 1'b0, $urandom_range(1, 4), 1'b0);
                1: glitch(1'b0, 1'b1, $urandom_range(1, 4), 1'b0);
                2: dbg_pulse(($urandom_range(0, 1) == 1) ? $urandom_range(2, 3) : 0);
                default: clr_pulse();
            endcase
            wait_drain(60, "random_op");
        end

        // 300 lock-loss events to saturate the counter
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            p = cyc;
            rs_if.pll_lock = 1'b0;
            abort_model(p + 3, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            rs_if.pll_lock = 1'b1;
            repeat (2) @(negedge clk);
        end
        reseq(p + 4);
        wait_drain(80, "saturate");
        check("lostcnt_saturated", rs_if.lock_lost_cnt, 255);

        // Asynchronous RESETN in the middle of FAB_REL
        @(negedge clk);
        p = cyc;
        rs_if.pll_lock = 1'b0;
        abort_model(p + 3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rs_if.pll_lock = 1'b1;
        push_snap(p + 4 + LSC, 1'b1, 1'b0);
        while (cyc < p + 5 + LSC) @(negedge clk);
        rst_n = 1'b0;
        m_cause = 4'b0001;
        m_cnt   = 8'h00;
        push_snap(cyc, 1'b0, 1'b0);
        #2;
        check("async_fab", rs_if.fabric_reset_n, 0);
        check("async_cpu", rs_if.cpu_reset_n, 0);
        check("async_cause", rs_if.reset_cause, 4'b0001);
        check("async_lostcnt", rs_if.lock_lost_cnt, 0);
        repeat (2) @(negedge clk);
        q = cyc;
        rst_n = 1'b1;
        reseq(q + 3);
        wait_drain(40, "after_resetn");

        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
